apb_slave_mem: RTL

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

---
 rtl/apb_slave_mem.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/apb_slave_mem.sv
// APB slave backed by a small word memory with a fixed number of wait states per access.
// Optional feature: define APB_SLVERR_EN to report out-of-range addresses on Pslverr.
module apb_slave_mem #(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 32,
    parameter int          NSEL     = 3,
    parameter int          SEL_IDX  = 0,
    parameter int          DEPTH    = 16,
    parameter int          WAIT_CYC = 0,
    parameter int unsigned RST_VAL  = 32'd25
) (
    input  logic                  Hclk,
    input  logic                  Hresetn,
    input  logic [NSEL-1:0]       Pselx,
    input  logic                  Penable,
    input  logic                  Pwrite,
    input  logic [ADDR_W-1:0]     Paddr,
    input  logic [DATA_W-1:0]     Pwdata,
    input  logic [DATA_W/8-1:0]   Pstrb,
    output logic [DATA_W-1:0]     Prdata,
    output logic                  Pready,
    output logic                  Pslverr
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int NB    = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t              state_r;
    logic [3:0]          cnt_r;
    logic [IDX_W-1:0]    idx_r;
    logic                write_r;
    logic                err_r;
    logic                pready_r;
    logic                pslverr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W-1:0]   prdata_r;
    logic [NB-1:0]       strb_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    logic                sel_s;
    logic                go_s;
    logic                live_err_s;
    logic                acc_write_s;
    logic                acc_err_s;
    logic                done_s;
    logic                wr_en_s;
    logic [IDX_W-1:0]    live_idx_s;
    logic [IDX_W-1:0]    acc_idx_s;
    logic [DATA_W-1:0]   rd_data_s;
    logic                unused_s;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [NB-1:0]     strb
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int b = 0; b < NB; b++) begin
            res[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return res;
    endfunction

    assign sel_s      = Pselx[SEL_IDX];
    assign go_s       = sel_s & Penable;
    assign live_idx_s = Paddr[IDX_W+1:2];

`ifdef APB_SLVERR_EN
    assign live_err_s = |(Paddr >> (IDX_W + 2));
`else
    assign live_err_s = 1'b0;
`endif

    // With no wait states the data phase completes on the SETUP->ACCESS edge, before the
    // attributes land in their registers, so the live bus values are used there.
    assign acc_idx_s   = (state_r == SETUP) ? live_idx_s : idx_r;
    assign acc_err_s   = (state_r == SETUP) ? live_err_s : err_r;
    assign acc_write_s = (state_r == SETUP) ? Pwrite     : write_r;

    assign done_s = ((state_r == SETUP) && go_s && (WAIT_CYC == 32'sd0)) ||
                    ((state_r == ACCESS) && !pready_r && (cnt_r == 4'd1) && go_s);

    assign rd_data_s = acc_err_s ? '0 : mem_r[acc_idx_s];
    assign wr_en_s   = (state_r == ACCESS) && pready_r && write_r && !err_r;
    assign unused_s  = ^{Pselx, Paddr};

    // Transfer FSM, wait counter, sampled attributes and registered bus outputs.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            idx_r     <= '0;
            write_r   <= 1'b0;
            err_r     <= 1'b0;
            wdata_r   <= '0;
            strb_r    <= '0;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            prdata_r  <= '0;
        end else begin
            pready_r  <= done_s;
            pslverr_r <= done_s & acc_err_s;
            if (done_s && !acc_write_s) begin
                prdata_r <= rd_data_s;
            end
            case (state_r)
                IDLE: begin
                    state_r <= (sel_s && !Penable) ? SETUP : IDLE;
                end
                SETUP: begin
                    if (go_s) begin
                        state_r <= ACCESS;
                        cnt_r   <= 4'(WAIT_CYC);
                        idx_r   <= live_idx_s;
                        write_r <= Pwrite;
                        wdata_r <= Pwdata;
                        strb_r  <= Pstrb;
                        err_r   <= live_err_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (pready_r) begin
                        state_r <= (sel_s && !Penable) ? SETUP : IDLE;
                    end else if (go_s) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        state_r <= IDLE;
                        cnt_r   <= 4'd0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

    // Word storage; the write lands at the edge that closes the Pready cycle.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= DATA_W'(RST_VAL);
            end
        end else if (wr_en_s) begin
            mem_r[idx_r] <= merge_bytes(mem_r[idx_r], wdata_r, strb_r);
        end
    end

    assign Prdata  = prdata_r;
    assign Pready  = pready_r;
    assign Pslverr = pslverr_r;

endmodule
